clock_divider_multi: RTL and testbench

Parametrised multi-channel clock divider and tick generator. It is the next generation of the fixed 1 kHz divider. Each of `NUM_CH` channels has its own enable, an output mode (50 % square wave or one-cycle tick), and a divisor that can be changed at runtime. Divisor changes are glitch-free through a load handshake. The block sits beside the display/timekeeping logic and supplies the scan, seconds and blink rates from the single board clock.

---
 rtl/clock_divider_multi.sv | 89 ++++++++
 tb/tb_clock_divider_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider / tick generator with per-channel enable,
// square or tick output mode and glitch-free runtime divisor reload.
module clock_divider_multi #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 27,
    parameter  int DIV_DEFAULT = 50000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic [NUM_CH-1:0] mode_i,
    input  logic              load_i,
    input  logic [CH_W-1:0]   load_ch_i,
    input  logic [CNT_W-1:0]  load_div_i,
    output logic              load_ack_o,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    localparam logic [CH_W:0]    LIM   = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] D_RST = CNT_W'(DIV_DEFAULT);

    logic w_load_ok;
    logic r_ack;

    // Out-of-range channel indices are silently dropped
    assign w_load_ok  = load_i && ({1'b0, load_ch_i} < LIM);
    assign load_ack_o = r_ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_load_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div_act;
        logic [CNT_W-1:0] r_div_shd;
        logic             r_pend;
        logic             r_sq;
        logic             r_tick;
        logic             w_tc;
        logic             w_sel;

        assign w_tc  = (r_cnt == r_div_act);
        assign w_sel = w_load_ok && (load_ch_i == CH_W'(g));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt     <= '0;
                r_div_act <= D_RST;
                r_div_shd <= D_RST;
                r_pend    <= 1'b0;
                r_sq      <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                if (!en_i[g]) begin
                    r_cnt  <= '0;
                    r_sq   <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_tc) begin
                    r_cnt  <= '0;
                    r_sq   <= ~r_sq;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_tick <= 1'b0;
                end
                // Shadow swaps in only at a period boundary or while idle
                if (r_pend && (!en_i[g] || w_tc)) begin
                    r_div_act <= r_div_shd;
                    r_pend    <= 1'b0;
                end
                if (w_sel) begin
                    r_div_shd <= load_div_i;
                    r_pend    <= 1'b1;
                end
            end
        end

        assign clk_o[g]  = mode_i[g] ? r_tick : r_sq;
        assign tick_o[g] = r_tick;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (5 channels, DIV_DEFAULT=3).
module tb_clock_divider_multi;

    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int DD  = 3;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NCH-1:0] en_i;
    logic [NCH-1:0] mode_i;
    logic           load_i;
    logic [CHW-1:0] load_ch_i;
    logic [CW-1:0]  load_div_i;
    logic           load_ack_o;
    logic [NCH-1:0] clk_o;
    logic [NCH-1:0] tick_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_divider_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DIV_DEFAULT(DD)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .load_i    (load_i),
        .load_ch_i (load_ch_i),
        .load_div_i(load_div_i),
        .load_ack_o(load_ack_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        load_i = 1'b0;
        cyc();
        rst_i  = 1'b0;
    endtask

    task automatic load(input int ch, input int d);
        load_i     = 1'b1;
        load_ch_i  = CHW'(ch);
        load_div_i = CW'(d);
    endtask

    initial begin
        logic [NCH-1:0] e_tick;
        logic [NCH-1:0] e_sq;
        rst_i      = 1'b1;
        en_i       = '1;
        mode_i     = '0;
        load_i     = 1'b0;
        load_ch_i  = '0;
        load_div_i = '0;

        // Reset state and default period 8 square / tick every 4
        do_reset();
        check("rst_clk", clk_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_ack", load_ack_o, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e_tick = (k % 4 == 0) ? 5'h1F : 5'h00;
            e_sq   = (((k / 4) % 2) == 1) ? 5'h1F : 5'h00;
            check($sformatf("sq_clk_%0d", k), clk_o, e_sq);
            check($sformatf("sq_tick_%0d", k), tick_o, e_tick);
        end

        // Reload ch1 (tick mode) mid-period: old D finishes, then D=1
        mode_i = 5'b00010;
        do_reset();
        cyc();
        load(1, 1);
        cyc();
        check("ld_ack", load_ack_o, 1);
        load_i = 1'b0;
        cyc();
        check("ld_ack_off", load_ack_o, 0);
        check("ld_t1_e3", tick_o[1], 0);
        cyc();
        check("ld_t1_e4", tick_o[1], 1);
        check("ld_t0_e4", tick_o[0], 1);
        cyc();
        check("ld_t1_e5", tick_o[1], 0);
        check("ld_c1_e5", clk_o[1], 0);
        cyc();
        check("ld_t1_e6", tick_o[1], 1);
        check("ld_c1_e6", clk_o[1], 1);
        check("ld_t0_e6", tick_o[0], 0);
        cyc();
        check("ld_t1_e7", tick_o[1], 0);
        cyc();
        check("ld_all_e8", tick_o, 5'h1F);

        // Invalid channel ignored; two loads to ch0, last wins
        mode_i = '0;
        do_reset();
        load(5, 1);
        cyc();
        check("bad_ack", load_ack_o, 0);
        load(0, 7);
        cyc();
        check("dbl_ack1", load_ack_o, 1);
        load(0, 2);
        cyc();
        check("dbl_ack2", load_ack_o, 1);
        load_i = 1'b0;
        cyc();
        check("dbl_ack_off", load_ack_o, 0);
        check("dbl_tick_e4", tick_o, 5'h1F);
        cyc(2);
        check("dbl_tick_e6", tick_o, 5'h00);
        cyc();
        check("dbl_tick_e7", tick_o, 5'h01);
        check("dbl_clk_e7", clk_o, 5'h1E);
        cyc();
        check("dbl_tick_e8", tick_o, 5'h1E);
        cyc(2);
        check("dbl_tick_e10", tick_o, 5'h01);

        // D=0 on ch3 (square) and ch4 (tick), applied while disabled
        en_i   = 5'h07;
        mode_i = 5'b10000;
        do_reset();
        load(3, 0);
        cyc();
        check("d0_ack3", load_ack_o, 1);
        load(4, 0);
        cyc();
        check("d0_ack4", load_ack_o, 1);
        load_i = 1'b0;
        cyc();
        check("d0_off", clk_o[4:3], 0);
        en_i = 5'h1F;
        for (int k = 4; k <= 8; k++) begin
            cyc();
            check($sformatf("d0_c3_%0d", k), clk_o[3], (k % 2 == 0) ? 1 : 0);
            check($sformatf("d0_t3_%0d", k), tick_o[3], 1);
            check($sformatf("d0_c4_%0d", k), clk_o[4], 1);
        end

        // Drop en[2] while high, load while idle, re-enable
        en_i   = 5'h1F;
        mode_i = '0;
        do_reset();
        cyc(5);
        check("en_pre", clk_o, 5'h1F);
        en_i[2] = 1'b0;
        cyc();
        check("en_clk_off", clk_o, 5'h1B);
        check("en_tick_off", tick_o[2], 0);
        load(2, 1);
        cyc();
        check("en_ld_ack", load_ack_o, 1);
        load_i = 1'b0;
        cyc();
        en_i[2] = 1'b1;
        cyc();
        check("en_t2_e9", tick_o[2], 0);
        cyc();
        check("en_tick_e10", tick_o, 5'h04);
        cyc();
        check("en_t2_e11", tick_o[2], 0);
        cyc();
        check("en_tick_e12", tick_o, 5'h1F);

        // Reset after a load, mid-period; load in the reset cycle dropped
        do_reset();
        cyc(5);
        check("rr_pre", clk_o, 5'h1F);
        load(0, 1);
        cyc();
        check("rr_ack", load_ack_o, 1);
        rst_i = 1'b1;
        load(1, 1);
        cyc();
        rst_i  = 1'b0;
        load_i = 1'b0;
        check("rr_ack_rst", load_ack_o, 0);
        check("rr_clk_rst", clk_o, 0);
        check("rr_tick_rst", tick_o, 0);
        cyc();
        check("rr_ack_drop", load_ack_o, 0);
        cyc();
        check("rr_tick_e9", tick_o, 0);
        cyc(2);
        check("rr_tick_e11", tick_o, 5'h1F);
        cyc(2);
        check("rr_tick_e13", tick_o, 0);
        cyc(2);
        check("rr_tick_e15", tick_o, 5'h1F);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
